// File: rtl/div_unit_param_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_param_if
// Purpose  : Request/response bundle between the EX stage and the
//            multi-cycle divider. EX drives operands and start/annul and
//            reads back the packed result and status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_param_if #(
  parameter int WIDTH = 32
);

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               divzero_o;
  logic               busy_o;

  // EX stage side: issues requests, consumes results
  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o,
    input  divzero_o,
    input  busy_o
  );

  // Divider side: consumes requests, produces results
  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o,
    output divzero_o,
    output busy_o
  );

endinterface
`default_nettype wire

// File: rtl/div_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_param
// Purpose  : Parametrised multi-cycle radix-2 restoring divider. Divides
//            WIDTH-bit operands (signed or unsigned) in WIDTH iterations and
//            returns {remainder, quotient}. Divide-by-zero short-circuits to
//            a flagged zero result; annul aborts from any non-idle state.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input wire logic          clk,
  input wire logic          rst,
  div_unit_param_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DZERO = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter value held during the final iteration
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_rem;      // partial remainder
  logic [WIDTH-1:0]   r_dvd;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
  logic [CNT_W-1:0]   r_cnt;
  logic               r_signed;
  logic               r_sign_q;
  logic               r_sign_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_divzero;
  logic               r_busy;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_req;
  logic               w_div_zero;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  // Operand magnitudes: negative signed operands are negated so the core
  // loop always works on unsigned values.
  assign w_neg_a    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_neg_b    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_mag_a    = w_neg_a ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_mag_b    = w_neg_b ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
  assign w_req      = bus.start_i & ~bus.annul_i;
  assign w_div_zero = (bus.opdata2_i == '0);

  // One restoring step. The remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the MSB of the WIDTH+1-bit
  // difference is a reliable borrow (negative) indicator.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

  // Sign correction applied to the final step's values. MIN/-1 naturally
  // wraps back to MIN because the magnitude quotient 2^(WIDTH-1) is
  // already the MIN bit pattern and sign_q is clear.
  assign w_quo_fix = (r_signed & r_sign_q) ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fix = (r_signed & r_sign_r) ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  // Control FSM plus datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_divzero <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_signed <= bus.signed_div_i;
            r_sign_q <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            r_sign_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            r_dvd    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= w_div_zero ? S_DZERO : S_BUSY;
          end
        end

        S_DZERO: begin
          if (bus.annul_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_divzero <= 1'b0;
            r_result  <= '0;
          end else begin
            r_state   <= S_DONE;
            r_result  <= '0;
            r_divzero <= 1'b1;
            r_ready   <= 1'b1;
          end
        end

        S_BUSY: begin
          if (bus.annul_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_divzero <= 1'b0;
            r_result  <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last_iter) begin
              r_state   <= S_DONE;
              r_result  <= {w_rem_fix, w_quo_fix};
              r_divzero <= 1'b0;
              r_ready   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Result is held while EX keeps start high; releasing start or
          // annulling returns to idle with cleared outputs.
          if (bus.annul_i || !bus.start_i) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_divzero <= 1'b0;
            r_result  <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o  = r_result;
  assign bus.ready_o   = r_ready;
  assign bus.divzero_o = r_divzero;
  assign bus.busy_o    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit_param
// Purpose  : Scoreboard bench for div_unit_param (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_param_if #(.WIDTH(32)) ifa ();
  div_unit_param_if #(.WIDTH(8))  ifb ();

  div_unit_param #(.WIDTH(32), .CNT_W(6)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  div_unit_param #(.WIDTH(8),  .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] res;
    logic        dz;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference: plain integer division with truncation toward zero
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, bit s);
    longint mask, sa, sb, qq, rr;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sb == 0) begin
      e.res = '0;
      e.dz  = 1'b1;
      return e;
    end
    if (s) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    qq    = sa / sb;
    rr    = sa % sb;
    e.res = 64'(((rr & mask) << w) | (qq & mask));
    e.dz  = 1'b0;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor A: pop the scoreboard on each new result
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ifa.ready_o && !prev_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_ready: got ready=1 want no pending result");
      end else begin
        e = q_a.pop_front();
        check("a_result", ifa.result_o, e.res);
        check("a_divzero", 64'(ifa.divzero_o), 64'(e.dz));
      end
    end
    prev_a = ifa.ready_o;
    if (rst && ifa.busy_o && !ifa.ready_o && !ifa.start_i && !ifa.annul_i) begin
      total++; bad++;
      $display("FAIL a_protocol: got start=0 while busy want start=1");
    end
  end

  // Monitor B
  logic prev_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ifb.ready_o && !prev_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_ready: got ready=1 want no pending result");
      end else begin
        e = q_b.pop_front();
        check("b_result", 64'(ifb.result_o), e.res);
        check("b_divzero", 64'(ifb.divzero_o), 64'(e.dz));
      end
    end
    prev_b = ifb.ready_o;
    if (rst && ifb.busy_o && !ifb.ready_o && !ifb.start_i && !ifb.annul_i) begin
      total++; bad++;
      $display("FAIL b_protocol: got start=0 while busy want start=1");
    end
  end

  // Full transaction on the 32-bit unit; entered just after a rising edge
  task automatic run_a(logic [31:0] a, logic [31:0] b, bit s, string nm, output logic [63:0] got);
    int   n;
    exp_t e;
    e = model(32, a, b, s);
    q_a.push_back(e);
    ifa.opdata1_i = a; ifa.opdata2_i = b; ifa.signed_div_i = s; ifa.start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!ifa.ready_o && n < 100);
    got = ifa.result_o;
    check({nm, "_latency"}, 64'(n), (b == 0) ? 64'd2 : 64'd33);
    // Operand changes while DONE must not disturb the held result
    @(posedge clk); #1;
    ifa.opdata1_i = $urandom; ifa.opdata2_i = $urandom;
    @(negedge clk);
    check({nm, "_hold"}, ifa.result_o, e.res);
    @(posedge clk); #1;
    ifa.start_i = 1'b0;
    @(posedge clk); #1;
    check({nm, "_clr"}, {ifa.result_o[61:0], ifa.ready_o, ifa.divzero_o}, 64'd0);
  endtask

  task automatic run_b(logic [7:0] a, logic [7:0] b, bit s, string nm, output logic [15:0] got);
    int   n;
    exp_t e;
    e = model(8, 32'(a), 32'(b), s);
    q_b.push_back(e);
    ifb.opdata1_i = a; ifb.opdata2_i = b; ifb.signed_div_i = s; ifb.start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!ifb.ready_o && n < 100);
    got = ifb.result_o;
    check({nm, "_latency"}, 64'(n), (b == 0) ? 64'd2 : 64'd9);
    @(posedge clk); #1;
    ifb.start_i = 1'b0;
    @(posedge clk); #1;
    check({nm, "_clr"}, {46'd0, ifb.result_o, ifb.ready_o, ifb.divzero_o}, 64'd0);
  endtask

  initial begin
    logic [63:0] g;
    logic [15:0] g8;
    logic [31:0] ra, rb;
    bit          rs;

    rst = 1'b0;
    ifa.signed_div_i = 1'b0; ifa.opdata1_i = '0; ifa.opdata2_i = '0; ifa.start_i = 1'b0; ifa.annul_i = 1'b0;
    ifb.signed_div_i = 1'b0; ifb.opdata1_i = '0; ifb.opdata2_i = '0; ifb.start_i = 1'b0; ifb.annul_i = 1'b0;
    #12;
    check("reset_outputs", {ifa.result_o[60:0], ifa.ready_o, ifa.divzero_o, ifa.busy_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_a(32'd100, 32'd7, 1'b0, "u100_7", g);
    check("u100_7_value", g, {32'd2, 32'd14});
    run_a(-32'sd7, 32'd2, 1'b1, "sm7_2", g);
    check("sm7_2_value", g, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_a(32'd7, -32'sd2, 1'b1, "s7_m2", g);
    check("s7_m2_value", g, {32'h0000_0001, 32'hFFFF_FFFD});
    run_a(32'h1234, 32'd0, 1'b0, "dz", g);
    check("dz_value", g, 64'd0);
    run_a(32'd9, 32'd3, 1'b0, "u9_3", g);
    check("u9_3_value", g, {32'd0, 32'd3});

    // Annul after ten iterations: no result may ever appear
    ifa.opdata1_i = 32'hFFFF_FFFF; ifa.opdata2_i = 32'd1; ifa.signed_div_i = 1'b0; ifa.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    ifa.annul_i = 1'b1; ifa.start_i = 1'b0;
    @(posedge clk); #1;
    ifa.annul_i = 1'b0;
    check("annul_busy", {62'd0, ifa.busy_o, ifa.ready_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("annul_idle", {62'd0, ifa.busy_o, ifa.ready_o}, 64'd0);

    run_a(32'd50, 32'd5, 1'b0, "u50_5", g);
    check("u50_5_value", g, {32'd0, 32'd10});
    run_a(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "min_m1", g);
    check("min_m1_value", g, {32'd0, 32'h8000_0000});

    // Asynchronous reset in the middle of a divide
    ifa.opdata1_i = 32'd12345; ifa.opdata2_i = 32'd17; ifa.signed_div_i = 1'b0; ifa.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst", {ifa.result_o[60:0], ifa.ready_o, ifa.divzero_o, ifa.busy_o}, 64'd0);
    ifa.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomised 32-bit traffic
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = 1'($urandom_range(0, 1));
      run_a(ra, rb, rs, "rand_a", g);
    end

    // 8-bit instance
    run_b(8'd200, 8'd3, 1'b0, "b200_3", g8);
    check("b200_3_value", 64'(g8), 64'h0242);
    run_b(8'h80, 8'h03, 1'b1, "bs80_3", g8);
    check("bs80_3_value", 64'(g8), 64'hFED6);
    for (int i = 0; i < 12; i++) begin
      ra = 32'($urandom_range(0, 255));
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_b(ra[7:0], rb[7:0], rs, "rand_b", g8);
    end

    repeat (5) @(posedge clk);
    #1;
    check("a_queue_empty", 64'(q_a.size()), 64'd0);
    check("b_queue_empty", 64'(q_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
